led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator; the parametrised successor to the single-LED 1 Hz blinker on the 50 MHz fabric clock. Each of NUM_CH channels independently runs OFF, ON, free-running BLINK, or counted BURST mode with its own half-period. A synchronous config write port, typically driven from an HPS-mapped register bridge, sets each channel. A global sync strobe phase-aligns the blinking channels.

---
 rtl/led_pattern_gen.sv | 129 ++++++++++++
 tb/tb_led_pattern_gen.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel OFF / ON / BLINK / counted BURST
// with programmable half-period, a config write port and a global phase-align strobe.
module led_pattern_gen #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 28,
  parameter int unsigned HALF_DEFAULT = 49999999,
  parameter logic [1:0]  RESET_MODE   = 2'b10,
  localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk50m,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic [7:0]        cfg_burst,
  input  logic              sync,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] burst_done
);

  localparam logic [1:0] MODE_OFF   = 2'b00;
  localparam logic [1:0] MODE_ON    = 2'b01;
  localparam logic [1:0] MODE_BLINK = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       remain_q, remain_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic             wr_hit_c;
    logic             sync_hit_c;

    // Channel indices never exceed NUM_CH-1, so out-of-range writes match nothing.
    assign wr_hit_c   = cfg_we && (32'(cfg_ch) == i);
    assign sync_hit_c = sync && ((mode_q == MODE_BLINK) || ((mode_q == MODE_BURST) && !done_q));

    // Next-state: write beats sync, sync beats normal counting.
    always_comb begin
      mode_d   = mode_q;
      half_d   = half_q;
      cnt_d    = cnt_q;
      remain_d = remain_q;
      led_d    = led_q;
      done_d   = done_q;
      if (wr_hit_c) begin
        mode_d = cfg_mode;
        half_d = cfg_half;
        cnt_d  = cfg_half;
        done_d = 1'b0;
        case (cfg_mode)
          MODE_OFF:   led_d = 1'b0;
          MODE_ON:    led_d = 1'b1;
          MODE_BLINK: led_d = 1'b1;
          default: begin
            if (cfg_burst == 8'd0) begin
              led_d    = 1'b0;
              done_d   = 1'b1;
              remain_d = 8'd0;
            end else begin
              led_d    = 1'b1;
              remain_d = cfg_burst;
            end
          end
        endcase
      end else if (sync_hit_c) begin
        cnt_d = half_q;
        led_d = 1'b1;
      end else begin
        case (mode_q)
          MODE_OFF: led_d = 1'b0;
          MODE_ON:  led_d = 1'b1;
          MODE_BLINK: begin
            if (cnt_q == CNT_W'(0)) begin
              cnt_d = half_q;
              led_d = ~led_q;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: begin
            if (done_q) begin
              led_d = 1'b0;
            end else if (cnt_q == CNT_W'(0)) begin
              cnt_d = half_q;
              led_d = ~led_q;
              // A falling edge consumes one pulse; the last one ends the burst.
              if (led_q) begin
                if (remain_q <= 8'd1) begin
                  remain_d = 8'd0;
                  done_d   = 1'b1;
                end else begin
                  remain_d = remain_q - 8'd1;
                end
              end
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        endcase
      end
    end

    always_ff @(posedge clk50m or negedge reset_n) begin
      if (!reset_n) begin
        mode_q   <= RESET_MODE;
        half_q   <= CNT_W'(HALF_DEFAULT);
        cnt_q    <= '0;
        remain_q <= '0;
        led_q    <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        mode_q   <= mode_d;
        half_q   <= half_d;
        cnt_q    <= cnt_d;
        remain_q <= remain_d;
        led_q    <= led_d;
        done_q   <= done_d;
      end
    end

    assign led[i]        = led_q;
    assign burst_done[i] = done_q;
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: directed vector table, hand-written corner sequences,
// and random config/sync traffic against a phase-anchor reference model.
module tb_led_pattern_gen;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 28;
  localparam int unsigned HD     = 9;

  logic             clk50m = 1'b0;
  logic             reset_n;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_half;
  logic [7:0]       cfg_burst;
  logic             sync;
  logic [3:0]       led, burst_done;

  logic             cfg_we3;
  logic [1:0]       cfg_ch3;
  logic             sync3 = 1'b0;
  logic [2:0]       led3, done3;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: a running channel is described by the edge where it last started a
  // high phase (anchor) and the pulses still owed at that anchor.
  int m_mode[NUM_CH], m_half[NUM_CH], m_anchor[NUM_CH], m_rem[NUM_CH];

  led_pattern_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .HALF_DEFAULT(HD), .RESET_MODE(2'b10)) u_dut (
    .clk50m(clk50m), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .sync(sync), .led(led), .burst_done(burst_done));

  led_pattern_gen #(.NUM_CH(3), .CNT_W(CNT_W), .HALF_DEFAULT(HD), .RESET_MODE(2'b10)) u_dut3 (
    .clk50m(clk50m), .reset_n(reset_n), .cfg_we(cfg_we3), .cfg_ch(cfg_ch3), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .cfg_burst(cfg_burst), .sync(sync3), .led(led3), .burst_done(done3));

  always #10 clk50m = ~clk50m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  function automatic int falls(int ch, int e);
    int t = e - m_anchor[ch];
    int p = m_half[ch] + 1;
    if (t < 0) return 0;
    return (t + p) / (2 * p);
  endfunction

  function automatic bit mdl_done(int ch, int e);
    return (m_mode[ch] == 3) && (falls(ch, e) >= m_rem[ch]);
  endfunction

  function automatic bit mdl_led(int ch, int e);
    int t = e - m_anchor[ch];
    int p = m_half[ch] + 1;
    if (m_mode[ch] == 0) return 1'b0;
    if (m_mode[ch] == 1) return 1'b1;
    if (t < 0 || mdl_done(ch, e)) return 1'b0;
    return ((t / p) % 2) == 0;
  endfunction

  task automatic mdl_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_mode[c] = 2; m_half[c] = HD; m_anchor[c] = 1; m_rem[c] = 0;
    end
  endtask

  task automatic mdl_edge(int e);
    for (int c = 0; c < NUM_CH; c++) begin
      if (sync && !(cfg_we && int'(cfg_ch) == c)) begin
        if (m_mode[c] == 2) begin
          m_anchor[c] = e;
        end else if (m_mode[c] == 3 && !mdl_done(c, e - 1)) begin
          m_rem[c]    = m_rem[c] - falls(c, e - 1);
          m_anchor[c] = e;
        end
      end
    end
    if (cfg_we && int'(cfg_ch) < NUM_CH) begin
      m_mode[cfg_ch] = int'(cfg_mode); m_half[cfg_ch] = int'(cfg_half);
      m_anchor[cfg_ch] = e; m_rem[cfg_ch] = int'(cfg_burst);
    end
  endtask

  // One clock: model advances with the inputs sampled at the edge, then outputs are compared.
  task automatic step();
    logic [3:0] el, ed;
    @(posedge clk50m);
    edge_n++;
    mdl_edge(edge_n);
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      el[c] = mdl_led(c, edge_n);
      ed[c] = mdl_done(c, edge_n);
    end
    chk("mdl_led", 32'(led), 32'(el));
    chk("mdl_done", 32'(burst_done), 32'(ed));
    chk("ch3dut_led", 32'(led3), (((edge_n - 1) / 10) % 2 == 0) ? 32'h7 : 32'h0);
    chk("ch3dut_done", 32'(done3), 32'h0);
    cfg_we = 1'b0; sync = 1'b0; cfg_we3 = 1'b0;
  endtask

  task automatic hold_release();
    repeat (2) @(posedge clk50m);
    #1;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_done", 32'(burst_done), 32'h0);
    #3 reset_n = 1'b1;
    edge_n = 0;
    mdl_reset();
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input int half, input int burst);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = CNT_W'(half); cfg_burst = 8'(burst);
  endtask

  typedef struct {
    logic       we;
    logic [1:0] ch;
    logic [1:0] mode;
    int         half;
    int         burst;
    logic       sy;
    int         n;
    logic [3:0] led;
    logic [3:0] done;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 2'd1, 2'b11, 3, 2, 1'b0, 1, 4'b1111, 4'b0000};
    tbl[1]  = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 3, 4'b1111, 4'b0000};
    tbl[2]  = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 1, 4'b1101, 4'b0000};
    tbl[3]  = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 4, 4'b1111, 4'b0000};
    tbl[4]  = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 2, 4'b0010, 4'b0000};
    tbl[5]  = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 2, 4'b0000, 4'b0010};
    tbl[6]  = '{1'b1, 2'd2, 2'b11, 5, 0, 1'b0, 1, 4'b0000, 4'b0110};
    tbl[7]  = '{1'b1, 2'd0, 2'b01, 0, 0, 1'b1, 1, 4'b1001, 4'b0110};
    tbl[8]  = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 10, 4'b0001, 4'b0110};
    tbl[9]  = '{1'b1, 2'd3, 2'b10, 0, 0, 1'b0, 1, 4'b1001, 4'b0110};
    tbl[10] = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 1, 4'b0001, 4'b0110};
    tbl[11] = '{1'b0, 2'd0, 2'b00, 0, 0, 1'b0, 1, 4'b1001, 4'b0110};
    tbl[12] = '{1'b1, 2'd0, 2'b00, 0, 0, 1'b0, 1, 4'b0000, 4'b0110};
    tbl[13] = '{1'b1, 2'd1, 2'b10, 2, 0, 1'b0, 1, 4'b1010, 4'b0100};

    reset_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0;
    cfg_burst = '0; sync = 1'b0; cfg_we3 = 1'b0; cfg_ch3 = '0;
    mdl_reset();

    // Default blink after reset, then the directed vector table.
    hold_release();
    for (int i = 0; i < 14; i++) begin
      cfg_we = tbl[i].we; cfg_ch = tbl[i].ch; cfg_mode = tbl[i].mode;
      cfg_half = CNT_W'(tbl[i].half); cfg_burst = 8'(tbl[i].burst); sync = tbl[i].sy;
      repeat (tbl[i].n) step();
      chk($sformatf("tbl%0d_led", i), 32'(led), 32'(tbl[i].led));
      chk($sformatf("tbl%0d_done", i), 32'(burst_done), 32'(tbl[i].done));
    end
    repeat (100) step();
    chk("burst_hold_done", 32'(burst_done[2]), 32'h1);

    // Sync alignment of two blink channels with different half-periods.
    reset_n = 1'b0;
    hold_release();
    step();
    chk("dflt_e1", 32'(led), 32'hf);
    repeat (9) step();
    chk("dflt_e10", 32'(led), 32'hf);
    step();
    chk("dflt_e11", 32'(led), 32'h0);
    wr(2'd2, 2'b10, 5, 0);
    step();
    wr(2'd3, 2'b10, 7, 0);
    step();
    cfg_we3 = 1'b1; cfg_ch3 = 2'd3; cfg_mode = 2'b00;
    step();
    repeat (22) step();
    sync = 1'b1;
    step();
    chk("sync_hi", 32'(led[3:2]), 32'h3);
    repeat (5) step();
    chk("sync_ch2_s5", 32'(led[2]), 32'h1);
    step();
    chk("sync_ch2_s6", 32'(led[2]), 32'h0);
    step();
    chk("sync_ch3_s7", 32'(led[3]), 32'h1);
    step();
    chk("sync_ch3_s8", 32'(led[3]), 32'h0);

    // Asynchronous reset in the middle of a burst.
    reset_n = 1'b0;
    hold_release();
    wr(2'd2, 2'b11, 4, 0);
    step();
    wr(2'd1, 2'b11, 3, 3);
    step();
    repeat (3) step();
    chk("pre_rst_led", 32'(led), 32'hb);
    chk("pre_rst_done", 32'(burst_done), 32'h4);
    #4 reset_n = 1'b0;
    #1;
    chk("async_led", 32'(led), 32'h0);
    chk("async_done", 32'(burst_done), 32'h0);
    hold_release();
    step();
    chk("post_rst_e1", 32'(led), 32'hf);
    repeat (10) step();
    chk("post_rst_e11", 32'(led), 32'h0);

    // Random writes and sync strobes against the model.
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0)
        wr(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      if ($urandom_range(0, 7) == 0) sync = 1'b1;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
